// File: rtl/stream_fifo_arbiter_pkg.sv
// Shared constants for the stream FIFO arbiter: header layout, defaults and FSM encoding.
package stream_fifo_arbiter_pkg;

  localparam logic [3:0]  HeaderTagDefault = 4'hE;
  localparam int unsigned TagW = 4;
  localparam int unsigned ChW  = 4;
  localparam int unsigned LenW = 8;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StCollect = 2'd1,
    StHeader  = 2'd2,
    StDrain   = 2'd3
  } state_e;

endpackage

// File: rtl/stream_fifo_arbiter_if.sv
// Source-side FWFT read ports and downstream FWFT read port of the arbiter.
interface stream_fifo_arbiter_if #(
  parameter int unsigned N_CH       = 4,
  parameter int unsigned DATA_WIDTH = 16
);
  logic [N_CH-1:0]            ch_enable;
  logic [N_CH-1:0]            ch_fifo_empty;
  logic [N_CH*DATA_WIDTH-1:0] ch_fifo_data;
  logic [N_CH-1:0]            ch_fifo_read;
  logic                       out_fifo_read;
  logic                       out_fifo_empty;
  logic [DATA_WIDTH-1:0]      out_fifo_data;
  logic                       burst_done;
  logic                       busy;

  modport master (
    input  ch_enable, ch_fifo_empty, ch_fifo_data, out_fifo_read,
    output ch_fifo_read, out_fifo_empty, out_fifo_data, burst_done, busy
  );

  modport slave (
    output ch_enable, ch_fifo_empty, ch_fifo_data, out_fifo_read,
    input  ch_fifo_read, out_fifo_empty, out_fifo_data, burst_done, busy
  );
endinterface

// File: rtl/stream_fifo_arbiter_rr_arbiter.sv
// Round-robin picker: first requesting channel above ptr_i (wrapping), as one-hot and index.
module stream_fifo_arbiter_rr_arbiter #(
  parameter int unsigned  N_CH = 4,
  localparam int unsigned IdxW = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic [N_CH-1:0] req_i,
  input  logic [IdxW-1:0] ptr_i,
  output logic [N_CH-1:0] gnt_o,
  output logic [IdxW-1:0] idx_o
);

  logic            found;
  logic [IdxW-1:0] cand;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    cand  = '0;
    for (int unsigned k = 1; k <= N_CH; k++) begin
      cand = IdxW'((32'(ptr_i) + k) % N_CH);
      if (!found && req_i[cand]) begin
        found       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
      end
    end
  end

endmodule

// File: rtl/stream_fifo_arbiter.sv
// Merges N FWFT sources into one FWFT stream of {header, data...} bursts, round-robin by channel.
module stream_fifo_arbiter
  import stream_fifo_arbiter_pkg::*;
#(
  parameter int unsigned N_CH       = 4,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned BURST_MAX  = 8,
  parameter logic [3:0]  HEADER_TAG = HeaderTagDefault
) (
  input logic                   BUS_CLK,
  input logic                   BUS_RST_N,
  stream_fifo_arbiter_if.master bus_io
);

  localparam int unsigned IdxW    = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int unsigned BufIdxW = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1;

  state_e                  state_q, state_d;
  logic [IdxW-1:0]         gnt_idx_q, gnt_idx_d, ptr_q, ptr_d;
  logic [LenW-1:0]         cnt_q, cnt_d, rd_q, rd_d;
  logic                    out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;
  logic [DATA_WIDTH-1:0]   burst_buf_q [BURST_MAX];

  logic [N_CH-1:0]         req, arb_gnt, ch_read;
  logic [IdxW-1:0]         arb_idx;
  logic                    src_empty, pop, free, last_rd;
  logic [DATA_WIDTH-1:0]   src_data, header;

  stream_fifo_arbiter_rr_arbiter #(.N_CH(N_CH)) u_rr (
    .req_i (req),
    .ptr_i (ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx)
  );

  assign req       = bus_io.ch_enable & ~bus_io.ch_fifo_empty;
  assign src_empty = bus_io.ch_fifo_empty[gnt_idx_q];
  assign src_data  = bus_io.ch_fifo_data[gnt_idx_q*DATA_WIDTH +: DATA_WIDTH];
  assign pop       = (state_q == StCollect) && !src_empty && (cnt_q < LenW'(BURST_MAX));
  assign free      = !out_valid_q || bus_io.out_fifo_read;
  assign last_rd   = (rd_q == cnt_q - LenW'(1));

  always_comb begin
    header = '0;
    header[DATA_WIDTH-1 -: TagW]      = HEADER_TAG;
    header[DATA_WIDTH-1-TagW -: ChW]  = ChW'(gnt_idx_q);
    header[LenW-1:0]                  = cnt_q;
  end

  always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
    if (!BUS_RST_N) state_q <= StIdle;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (|arb_gnt) state_d = StCollect;
      // Leave on the pop that fills the buffer so a full burst never costs an extra cycle.
      StCollect: if ((pop && cnt_q == LenW'(BURST_MAX - 1)) || (src_empty && cnt_q != '0))
                   state_d = StHeader;
      StHeader:  if (free) state_d = StDrain;
      StDrain:   if (free && last_rd) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_comb begin
    gnt_idx_d   = gnt_idx_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    rd_d        = rd_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_valid_d = out_valid_q && !bus_io.out_fifo_read;
    ch_read     = '0;
    unique case (state_q)
      StIdle: begin
        if (|arb_gnt) begin
          gnt_idx_d = arb_idx;
          cnt_d     = '0;
        end
      end
      StCollect: begin
        if (pop) begin
          ch_read = N_CH'(1) << gnt_idx_q;
          cnt_d   = cnt_q + LenW'(1);
        end
      end
      StHeader: begin
        if (free) begin
          out_data_d  = header;
          out_valid_d = 1'b1;
          out_last_d  = 1'b0;
          rd_d        = '0;
        end
      end
      StDrain: begin
        if (free) begin
          out_data_d  = burst_buf_q[BufIdxW'(rd_q)];
          out_valid_d = 1'b1;
          out_last_d  = last_rd;
          rd_d        = rd_q + LenW'(1);
          if (last_rd) ptr_d = gnt_idx_q;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
    if (!BUS_RST_N) begin
      gnt_idx_q   <= '0;
      ptr_q       <= IdxW'(N_CH - 1);
      cnt_q       <= '0;
      rd_q        <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
    end else begin
      gnt_idx_q   <= gnt_idx_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      rd_q        <= rd_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
    end
  end

  // Burst storage carries no reset; contents are only read after being written in COLLECT.
  always_ff @(posedge BUS_CLK) begin
    if (pop) burst_buf_q[BufIdxW'(cnt_q)] <= src_data;
  end

  assign bus_io.ch_fifo_read   = ch_read;
  assign bus_io.out_fifo_empty = !out_valid_q;
  assign bus_io.out_fifo_data  = out_data_q;
  assign bus_io.burst_done     = out_valid_q && bus_io.out_fifo_read && out_last_q;
  assign bus_io.busy           = (state_q != StIdle) || out_valid_q;

endmodule

// File: tb/tb_stream_fifo_arbiter.sv
// Scoreboard bench: source FIFO models feed the arbiter, a reference model predicts the stream.
module tb_stream_fifo_arbiter;

  localparam int unsigned NCh  = 4;
  localparam int unsigned Dw   = 16;
  localparam int unsigned Bmax = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  stream_fifo_arbiter_if #(.N_CH(NCh), .DATA_WIDTH(Dw)) bus ();

  stream_fifo_arbiter #(
    .N_CH       (NCh),
    .DATA_WIDTH (Dw),
    .BURST_MAX  (Bmax),
    .HEADER_TAG (4'hE)
  ) dut (
    .BUS_CLK   (clk),
    .BUS_RST_N (rst_n),
    .bus_io    (bus)
  );

  logic [Dw-1:0]  src_q [NCh][$];
  logic [Dw-1:0]  mdl_q [NCh][$];
  logic [Dw-1:0]  exp_data [$];
  logic           exp_last [$];
  int             pops [NCh];
  int             n_chk  = 0;
  int             n_pass = 0;
  int             mdl_ptr;
  logic [NCh-1:0] smp_mask;
  logic [Dw-1:0]  smp_data;
  logic           smp_busy;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic refresh();
    for (int i = 0; i < NCh; i++) begin
      bus.ch_fifo_empty[i]         = (src_q[i].size() == 0);
      bus.ch_fifo_data[i*Dw +: Dw] = (src_q[i].size() == 0) ? '0 : src_q[i][0];
    end
  endtask

  task automatic push(input int ch, input logic [Dw-1:0] w);
    src_q[ch].push_back(w);
    mdl_q[ch].push_back(w);
    refresh();
  endtask

  // Reference: round-robin over enabled channels with pending data, bursts of up to Bmax words.
  task automatic predict();
    int c, n;
    bit found;
    forever begin
      found = 1'b0;
      c     = 0;
      for (int k = 1; k <= NCh; k++) begin
        if (!found) begin
          c = (mdl_ptr + k) % NCh;
          if (bus.ch_enable[c] && mdl_q[c].size() > 0) found = 1'b1;
        end
      end
      if (!found) return;
      n = (mdl_q[c].size() > Bmax) ? Bmax : mdl_q[c].size();
      exp_data.push_back(Dw'(16'hE000 | (c << 8) | n));
      exp_last.push_back(1'b0);
      for (int j = 0; j < n; j++) begin
        exp_data.push_back(mdl_q[c].pop_front());
        exp_last.push_back(j == n - 1);
      end
      mdl_ptr = c;
    end
  endtask

  // Sample at negedge; inputs only change #1 after posedge, so the sampled pops are the ones taken.
  task automatic tick();
    logic pop, done;
    @(negedge clk);
    smp_mask = bus.ch_fifo_read;
    smp_data = bus.out_fifo_data;
    smp_busy = bus.busy;
    pop      = bus.out_fifo_read && !bus.out_fifo_empty;
    done     = bus.burst_done;
    if (pop) begin
      if (exp_data.size() == 0) check("extra_word", 32'(smp_data), 32'hdead_beef);
      else begin
        check("word", 32'(smp_data), 32'(exp_data.pop_front()));
        check("burst_done", 32'(done), 32'(exp_last.pop_front()));
      end
    end else if (done) begin
      check("stray_done", 32'(done), 32'd0);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < NCh; i++) begin
      if (smp_mask[i]) begin
        if (src_q[i].size() > 0) void'(src_q[i].pop_front());
        pops[i]++;
      end
    end
    refresh();
  endtask

  task automatic drain(input string tag);
    int i;
    i = 0;
    tick();
    while ((exp_data.size() != 0 || smp_busy) && i < 2000) begin
      tick();
      i++;
    end
    check({tag, "_left"}, 32'(exp_data.size()), 32'd0);
    check({tag, "_idle"}, 32'(smp_busy), 32'd0);
  endtask

  task automatic clear_pops();
    for (int i = 0; i < NCh; i++) pops[i] = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    exp_data.delete();
    exp_last.delete();
    mdl_ptr = NCh - 1;
    for (int i = 0; i < NCh; i++) begin
      src_q[i].delete();
      mdl_q[i].delete();
    end
    clear_pops();
    refresh();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int changes, late_pops, waited;
    logic [Dw-1:0] held;
    bus.ch_enable     = '1;
    bus.out_fifo_read = 1'b1;
    bus.ch_fifo_data  = '0;
    mdl_ptr           = NCh - 1;
    clear_pops();
    refresh();
    repeat (2) @(posedge clk);
    #1;
    check("rst_empty", 32'(bus.out_fifo_empty), 32'd1);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_read", 32'(bus.ch_fifo_read), 32'd0);
    check("rst_data", 32'(bus.out_fifo_data), 32'd0);
    check("rst_done", 32'(bus.burst_done), 32'd0);
    rst_n = 1'b1;

    // Single short burst from ch0.
    push(0, 16'hA001); push(0, 16'hA002); push(0, 16'hA003);
    predict();
    drain("t1");
    check("t1_pops0", 32'(pops[0]), 32'd3);

    // 20 words on ch1 split 8/8/4, with a 50-cycle downstream stall mid-drain.
    clear_pops();
    for (int i = 0; i < 20; i++) push(1, Dw'(16'h1000 + i));
    predict();
    repeat (14) tick();
    bus.out_fifo_read = 1'b0;
    changes = 0;
    late_pops = 0;
    held = bus.out_fifo_data;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (smp_data !== held) changes++;
      if (i >= 12 && smp_mask != '0) late_pops++;
    end
    check("t4_stable", 32'(changes), 32'd0);
    check("t4_no_pops", 32'(late_pops), 32'd0);
    check("t4_valid", 32'(bus.out_fifo_empty), 32'd0);
    bus.out_fifo_read = 1'b1;
    drain("t2");
    check("t2_pops1", 32'(pops[1]), 32'd20);

    // Three channels from reset: order ch0, ch2, ch3.
    do_reset();
    for (int c = 0; c < NCh; c++) begin
      if (c != 1) begin
        push(c, Dw'(16'h3000 + c * 16));
        push(c, Dw'(16'h3001 + c * 16));
      end
    end
    predict();
    drain("t3");
    check("t3_pops0", 32'(pops[0]), 32'd2);
    check("t3_pops2", 32'(pops[2]), 32'd2);
    check("t3_pops3", 32'(pops[3]), 32'd2);

    // Reset during COLLECT of ch1; popped words are lost, ch0 wins afterwards.
    clear_pops();
    for (int i = 0; i < 6; i++) begin
      src_q[1].push_back(Dw'(16'h5000 + i));
    end
    refresh();
    waited = 0;
    while (pops[1] < 2 && waited < 20) begin
      tick();
      waited++;
    end
    check("t5_collecting", 32'(pops[1]), 32'd2);
    rst_n = 1'b0;
    #1;
    check("t5_rst_empty", 32'(bus.out_fifo_empty), 32'd1);
    check("t5_rst_busy", 32'(bus.busy), 32'd0);
    check("t5_rst_read", 32'(bus.ch_fifo_read), 32'd0);
    check("t5_rst_done", 32'(bus.burst_done), 32'd0);
    exp_data.delete();
    exp_last.delete();
    mdl_q[1] = src_q[1];
    mdl_ptr = NCh - 1;
    push(0, 16'hC0DE);
    predict();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drain("t5");
    check("t5_src1_left", 32'(src_q[1].size()), 32'd0);

    // Disabled ch0 is never granted; dropping ch1's enable mid-burst changes nothing.
    do_reset();
    bus.ch_enable = 4'b1110;
    push(0, 16'h6000); push(0, 16'h6001);
    push(1, 16'h6100); push(1, 16'h6101); push(1, 16'h6102);
    push(2, 16'h6200); push(2, 16'h6201);
    predict();
    repeat (2) tick();
    bus.ch_enable[1] = 1'b0;
    drain("t6");
    check("t6_ch0_pops", 32'(pops[0]), 32'd0);
    check("t6_ch0_left", 32'(src_q[0].size()), 32'd2);
    check("t6_ch1_pops", 32'(pops[1]), 32'd3);
    bus.ch_enable[0] = 1'b1;
    predict();
    drain("t6b");
    check("t6b_ch0_pops", 32'(pops[0]), 32'd2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
